// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - shared encodings for pc_unit; FAULT state exists only under PC_ALIGN_CHECK_EN
package pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
`ifdef PC_ALIGN_CHECK_EN
    ST_FAULT = 2'b10,
`endif
    ST_HALT  = 2'b01
  } pc_state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational PC+4 and next-PC target selection
module pc_target_calc
  import pc_unit_pkg::*;
(
  input  logic [31:0] PC,
  input  logic [31:0] ImmExt,
  input  logic [25:0] JAddr,
  input  logic [31:0] RsData,
  input  logic [1:0]  PCSrc,
  output logic [31:0] PC4,
  output logic [31:0] NextPC
);

  assign PC4 = PC + PC_INC;

  // ImmExt counts words, so scale to bytes before adding
  always_comb begin
    NextPC = PC4;
    case (PCSrc)
      PCSRC_SEQ: NextPC = PC4;
      PCSRC_BR:  NextPC = PC4 + (ImmExt << 2);
      PCSRC_J:   NextPC = {PC4[31:28], JAddr, 2'b00};
      PCSRC_JR:  NextPC = RsData;
      default:   NextPC = PC4;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - PC register, sticky halt/fault FSM and update counter
// Optional misaligned-target fault: define PC_ALIGN_CHECK_EN.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic [31:0]      ImmExt,
  input  logic [25:0]      JAddr,
  input  logic [31:0]      RsData,
  input  logic             Halt,
  output logic [31:0]      PC,
  output logic [31:0]      PC4,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] UpdCnt
);

  pc_state_t        state, state_nxt;
  logic [31:0]      pc_q, pc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [31:0]      next_pc;

  pc_target_calc u_calc (
    .PC     (pc_q),
    .ImmExt (ImmExt),
    .JAddr  (JAddr),
    .RsData (RsData),
    .PCSrc  (PCSrc),
    .PC4    (PC4),
    .NextPC (next_pc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_RUN;
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Halt is checked first so it wins over both the write and a misaligned target
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    cnt_nxt   = cnt_q;
    case (state)
      ST_RUN: begin
        if (PCWre) begin
          if (Halt) begin
            state_nxt = ST_HALT;
`ifdef PC_ALIGN_CHECK_EN
          end else if (next_pc[1:0] != 2'b00) begin
            state_nxt = ST_FAULT;
`endif
          end else begin
            pc_nxt  = next_pc;
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_nxt = state;
    endcase
  end

  assign PC     = pc_q;
  assign UpdCnt = cnt_q;
  assign Halted = (state == ST_HALT);
`ifdef PC_ALIGN_CHECK_EN
  assign Fault  = (state == ST_FAULT);
`else
  assign Fault  = 1'b0;
`endif

endmodule
